postfix_eval_ctrl: RTL

POSTFIX_EVAL_CTRL -- requirements
Module: postfix_eval_ctrl

---
 rtl/pec_pkg.sv | 27 ++
 rtl/pec_operand_stack.sv | 69 ++++++
 rtl/postfix_eval_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pec_pkg.sv
// Shared codes for the postfix evaluator: token types, ALU op codes,
// error codes and the controller state encoding.
package pec_pkg;

    localparam logic [1:0] TOK_NUM = 2'b00;
    localparam logic [1:0] TOK_OP  = 2'b01;
    localparam logic [1:0] TOK_END = 2'b10;
    localparam logic [1:0] TOK_RSV = 2'b11;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_MALF = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_DIVZ = 2'b11;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_ALU_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/pec_operand_stack.sv
// Operand stack for the postfix evaluator: push one, pop two, clear.
// Ports: clk, rst (async, active-high); push/push_data; pop2; clear;
//        count, full, empty; top = entry[count-1], next = entry[count-2],
//        bottom = entry[0].
module pec_operand_stack
    import pec_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop2,
    input  logic                       clear,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [W-1:0]               top,
    output logic [W-1:0]               next,
    output logic [W-1:0]               bottom
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] idx_top, idx_next;

    // Low bits wrap correctly even when count == DEPTH.
    assign idx_top  = count_q[AW-1:0] - AW'(1);
    assign idx_next = count_q[AW-1:0] - AW'(2);

    assign count  = count_q;
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign top    = mem_q[idx_top];
    assign next   = mem_q[idx_next];
    assign bottom = mem_q[0];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push && !full) begin
            mem_d[count_q[AW-1:0]] = push_data;
            count_d = count_q + CW'(1);
        end else if (pop2 && !empty && count_q != CW'(1)) begin
            count_d = count_q - CW'(2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/postfix_eval_ctrl.sv
// Postfix expression evaluator controller driving a shared external ALU.
// Ports: clk, rst (async, active-high); tok_valid/tok_ready/tok_type/
//        tok_data token input; alu_req/alu_op/alu_a/alu_b/alu_ack/alu_res
//        ALU handshake; res_valid/res_ready/res_data/err result output.
// Option: PEC_DIVZERO_CHECK_EN traps div-by-zero locally with err=11.
module postfix_eval_ctrl
    import pec_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic [1:0]   tok_type,
    input  logic [W-1:0] tok_data,
    output logic         alu_req,
    output logic [1:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic         alu_ack,
    input  logic [W-1:0] alu_res,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [1:0]   err
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_q, state_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic [1:0]    alu_op_q, alu_op_d;
    logic [W-1:0]  res_data_q, res_data_d;
    logic [1:0]    err_q, err_d;

    logic          push, pop2, clear;
    logic [W-1:0]  push_data;
    logic [CW-1:0] count;
    logic          full, empty;
    logic [W-1:0]  top, next, bottom;

    pec_operand_stack #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop2      (pop2),
        .clear     (clear),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .top       (top),
        .next      (next),
        .bottom    (bottom)
    );

    assign tok_ready = (state_q == ST_ACCEPT);
    assign alu_req   = (state_q == ST_ALU_WAIT);
    assign res_valid = (state_q == ST_DONE) || (state_q == ST_ERROR);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_data  = res_data_q;
    assign err       = err_q;

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_data_d = res_data_q;
        err_d      = err_q;
        push       = 1'b0;
        pop2       = 1'b0;
        clear      = 1'b0;
        push_data  = tok_data;

        unique case (state_q)
            ST_ACCEPT: begin
                if (tok_valid) begin
                    unique case (tok_type)
                        TOK_NUM: begin
                            if (full) begin
                                state_d    = ST_ERROR;
                                err_d      = ERR_OVF;
                                res_data_d = '0;
                            end else begin
                                push = 1'b1;
                            end
                        end
                        TOK_OP: begin
                            if (empty || count == CW'(1)) begin
                                state_d    = ST_ERROR;
                                err_d      = ERR_MALF;
                                res_data_d = '0;
`ifdef PEC_DIVZERO_CHECK_EN
                            end else if (tok_data[1:0] == OP_DIV &&
                                         top == '0) begin
                                state_d    = ST_ERROR;
                                err_d      = ERR_DIVZ;
                                res_data_d = '0;
`endif
                            end else begin
                                alu_a_d  = next;
                                alu_b_d  = top;
                                alu_op_d = tok_data[1:0];
                                pop2     = 1'b1;
                                state_d  = ST_ALU_WAIT;
                            end
                        end
                        TOK_END: begin
                            if (count == CW'(1)) begin
                                state_d    = ST_DONE;
                                err_d      = ERR_NONE;
                                res_data_d = bottom;
                            end else begin
                                state_d    = ST_ERROR;
                                err_d      = ERR_MALF;
                                res_data_d = '0;
                            end
                        end
                        default: begin
                            state_d    = ST_ERROR;
                            err_d      = ERR_MALF;
                            res_data_d = '0;
                        end
                    endcase
                end
            end
            ST_ALU_WAIT: begin
                push_data = alu_res;
                if (alu_ack) begin
                    push    = 1'b1;
                    state_d = ST_ACCEPT;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (res_ready) begin
                    clear      = 1'b1;
                    state_d    = ST_ACCEPT;
                    res_data_d = '0;
                    err_d      = ERR_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACCEPT;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            res_data_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            res_data_q <= res_data_d;
            err_q      <= err_d;
        end
    end

endmodule
